// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store. Each access is strobe -> fixed read latency -> one-cycle ready.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_wstrb,
  output logic                    ls_ready,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy
);
  localparam int CNT_WIDTH = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_next;
  logic                 grant_ls;
  logic                 last_ls;
  logic                 pick_ls;
  logic [CNT_WIDTH-1:0] cnt;

  // On a tie the side not served last wins; a lone requester always wins.
  assign pick_ls = ls_req & (~if_req | ~last_ls);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // mem_we is only ever set for a granted store, so it selects the no-WAIT path.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (if_req | ls_req) state_next = ISSUE;
      ISSUE:   state_next = mem_we ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_ls  <= 1'b0;
      last_ls   <= 1'b1;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wstrb <= '0;
      case (state)
        IDLE: if (if_req | ls_req) begin
          grant_ls <= pick_ls;
          last_ls  <= pick_ls;
          mem_en   <= 1'b1;
          if (pick_ls) begin
            mem_we    <= ls_we;
            mem_wstrb <= ls_we ? ls_wstrb : '0;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
          end else begin
            mem_addr  <= if_addr;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == '0) begin
            if (grant_ls) ls_rdata <= mem_rdata;
            else          if_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign if_ready = (state == RESP) & ~grant_ls;
  assign ls_ready = (state == RESP) &  grant_ls;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1, one at 3.
// Inputs driven and outputs sampled on the falling edge.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic        if_req = 0, ls_req = 0, ls_we = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
  logic [3:0]  ls_wstrb = 0;
  logic        if_ready, ls_ready, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        if_req3 = 0, ls_req3 = 0, ls_we3 = 0;
  logic [31:0] if_addr3 = 0, ls_addr3 = 0, ls_wdata3 = 0, mem_rdata3 = 0;
  logic [3:0]  ls_wstrb3 = 0;
  logic        if_ready3, ls_ready3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, ls_rdata3, mem_addr3, mem_wdata3;
  logic [3:0]  mem_wstrb3;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
    .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
    .ls_wstrb(ls_wstrb3), .ls_ready(ls_ready3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_wstrb(mem_wstrb3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3));

  task automatic test_reset();
    #1;
    checks++;
    if ({if_ready, ls_ready, mem_en, mem_we, mem_wstrb, busy} !== 9'h0 ||
        if_rdata !== 32'h0 || ls_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ctl=%b if_rdata=%h ls_rdata=%h addr=%h wdata=%h, expected all zero",
               {if_ready, ls_ready, mem_en, mem_we, mem_wstrb, busy}, if_rdata, ls_rdata, mem_addr, mem_wdata);
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: busy=%b mem_en=%b, expected 0 0", busy, mem_en);
      end
    end
  endtask

  task automatic test_single_fetch();
    if_addr = 32'h40; if_req = 1'b1; mem_rdata = 32'h0;
    @(negedge clock);
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue: en=%b addr=%h we=%b strb=%h busy=%b, expected 1 00000040 0 0 1",
               mem_en, mem_addr, mem_we, mem_wstrb, busy);
    end
    mem_rdata = 32'hDEADBEEF;
    @(negedge clock);
    checks++;
    if (if_ready !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait: ready=%b en=%b busy=%b, expected 0 0 1", if_ready, mem_en, busy);
    end
    @(negedge clock);
    checks++;
    if (if_ready !== 1'b1 || ls_ready !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_resp: if_ready=%b ls_ready=%b if_rdata=%h, expected 1 0 deadbeef",
               if_ready, ls_ready, if_rdata);
    end
    if_req = 1'b0; mem_rdata = 32'h0BADF00D;
    @(negedge clock);
    checks++;
    if (if_ready !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_hold: ready=%b busy=%b if_rdata=%h, expected 0 0 deadbeef", if_ready, busy, if_rdata);
    end
  endtask

  task automatic test_store();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'h12345678; ls_wstrb = 4'b0011;
    @(negedge clock);
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h100 ||
        mem_wdata !== 32'h12345678 || ls_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_issue: en=%b we=%b strb=%b addr=%h wdata=%h ready=%b, expected 1 1 0011 00000100 12345678 0",
               mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata, ls_ready);
    end
    @(negedge clock);
    checks++;
    if (ls_ready !== 1'b1 || ls_rdata !== 32'h0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
        mem_wstrb !== 4'h0 || mem_addr !== 32'h100 || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_resp: ls_ready=%b ls_rdata=%h en=%b we=%b strb=%b addr=%h if_ready=%b, expected 1 0 0 0 0000 00000100 0",
               ls_ready, ls_rdata, mem_en, mem_we, mem_wstrb, mem_addr, if_ready);
    end
    ls_req = 1'b0; ls_we = 1'b0; ls_wstrb = 4'h0;
    @(negedge clock);
    checks++;
    if (ls_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL store_done: ls_ready=%b busy=%b, expected 0 0", ls_ready, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; mem_rdata = 32'h55555555;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || mem_en !== 1'b0 || ls_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_wait: busy=%b en=%b ready=%b, expected 1 0 0", busy, mem_en, ls_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({if_ready, ls_ready, mem_en, mem_we, mem_wstrb, busy} !== 9'h0 ||
        if_rdata !== 32'h0 || ls_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: ctl=%b if_rdata=%h ls_rdata=%h addr=%h wdata=%h, expected all zero",
               {if_ready, ls_ready, mem_en, mem_we, mem_wstrb, busy}, if_rdata, ls_rdata, mem_addr, mem_wdata);
    end
    ls_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0 || ls_ready !== 1'b0 || ls_rdata !== 32'h0) begin
        errors++;
        $display("FAIL abandoned: busy=%b en=%b ready=%b ls_rdata=%h, expected 0 0 0 0",
                 busy, mem_en, ls_ready, ls_rdata);
      end
    end
  endtask

  // Both held from reset: IF, LS, IF, LS; then both drop mid-access of the 5th.
  task automatic test_tie_fairness();
    logic [31:0] exp_if, exp_ls, val;
    logic        exp_is_ls;
    exp_if = 32'h0; exp_ls = 32'h0;
    if_addr = 32'h10; ls_addr = 32'h20; ls_we = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      exp_is_ls = (k % 2) == 1;
      val = 32'hA0000000 + k;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== (exp_is_ls ? 32'h20 : 32'h10)) begin
        errors++;
        $display("FAIL tie_issue%0d: en=%b addr=%h, expected 1 %h", k, mem_en, mem_addr,
                 exp_is_ls ? 32'h20 : 32'h10);
      end
      mem_rdata = val;
      if (exp_is_ls) exp_ls = val; else exp_if = val;
      @(negedge clock);
      @(negedge clock);
      mem_rdata = 32'hFFFFFFFF;
      checks++;
      if (if_ready !== !exp_is_ls || ls_ready !== exp_is_ls || if_rdata !== exp_if || ls_rdata !== exp_ls) begin
        errors++;
        $display("FAIL tie_resp%0d: if_ready=%b ls_ready=%b if_rdata=%h ls_rdata=%h, expected %b %b %h %h",
                 k, if_ready, ls_ready, if_rdata, ls_rdata, !exp_is_ls, exp_is_ls, exp_if, exp_ls);
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle%0d: busy=%b en=%b, expected 0 0", k, busy, mem_en);
      end
      @(negedge clock);
    end
    if_req = 1'b0; ls_req = 1'b0; mem_rdata = 32'hB0B0B0B0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (if_ready !== 1'b1 || if_rdata !== 32'hB0B0B0B0 || ls_rdata !== exp_ls) begin
      errors++;
      $display("FAIL dropped_req: if_ready=%b if_rdata=%h ls_rdata=%h, expected 1 b0b0b0b0 %h",
               if_ready, if_rdata, ls_rdata, exp_ls);
    end
    @(negedge clock);
  endtask

  task automatic test_held_request();
    int first, second;
    first = -1; second = -1;
    if_addr = 32'h80; if_req = 1'b1;
    for (int c = 0; c < 20 && second < 0; c++) begin
      @(negedge clock);
      if (mem_en === 1'b1) begin
        if (first < 0) first = c;
        else           second = c;
      end
    end
    if_req = 1'b0;
    checks++;
    if (second < 0 || second - first != 4) begin
      errors++;
      $display("FAIL held_spacing: first=%0d second=%0d, expected spacing 4", first, second);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_drain: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_latency();
    ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h8; mem_rdata3 = 32'h11111111;
    @(negedge clock);
    checks++;
    if (mem_en3 !== 1'b1 || mem_addr3 !== 32'h8 || mem_we3 !== 1'b0) begin
      errors++;
      $display("FAIL lat_issue: en=%b addr=%h we=%b, expected 1 00000008 0", mem_en3, mem_addr3, mem_we3);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clock);
      checks++;
      if (ls_ready3 !== 1'b0 || ls_rdata3 !== 32'h0 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL lat_wait_c%0d: ready=%b ls_rdata=%h busy=%b, expected 0 0 1", c, ls_ready3, ls_rdata3, busy3);
      end
      if (c == 4) mem_rdata3 = 32'hCAFEF00D;
    end
    @(negedge clock);
    checks++;
    if (ls_ready3 !== 1'b1 || ls_rdata3 !== 32'hCAFEF00D || if_rdata3 !== 32'h0) begin
      errors++;
      $display("FAIL lat_resp: ready=%b ls_rdata=%h if_rdata=%h, expected 1 cafef00d 0", ls_ready3, ls_rdata3, if_rdata3);
    end
    ls_req3 = 1'b0; mem_rdata3 = 32'h0;
    @(negedge clock);
    checks++;
    if (ls_ready3 !== 1'b0 || busy3 !== 1'b0 || ls_rdata3 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lat_hold: ready=%b busy=%b ls_rdata=%h, expected 0 0 cafef00d", ls_ready3, busy3, ls_rdata3);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_reset_mid_wait();
    test_tie_fairness();
    test_held_request();
    test_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
